// File: rtl/btb_predictor_pkg.sv
// Shared types and constants for the branch target buffer: entry layout,
// 2-bit direction counter encodings and the saturating counter step.
package btb_predictor_pkg;

  localparam int unsigned BTB_ENTRIES = 8;
  localparam int unsigned BTB_IDX_W   = 3;
  localparam int unsigned BTB_TAG_W   = 30;
  localparam int unsigned BTB_AGE_W   = 3;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [31:0]          target;
    ctr_e                 ctr;
  } btb_entry_t;

  // Saturating step toward the resolved direction
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    case (c)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage

// File: rtl/btb_replace.sv
// Victim selection for the BTB. Define BTB_LRU_EN for true-LRU ages,
// otherwise a round-robin pointer advanced on every eviction.
module btb_replace
  import btb_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 touch_en,
  input  logic [BTB_IDX_W-1:0] touch_idx,
  input  logic                 alloc_evict,
  output logic [BTB_IDX_W-1:0] victim_idx_c
);

  localparam int unsigned IDX_W = BTB_IDX_W;
  localparam int unsigned AGE_W = BTB_AGE_W;

`ifdef BTB_LRU_EN
  logic [AGE_W-1:0] ages_q [ENTRIES];
  logic [AGE_W-1:0] ages_d [ENTRIES];
  logic [AGE_W-1:0] best_age;
  logic             unused_evict;

  assign unused_evict = alloc_evict;

  // Entries no older than the touched one age by 1, so the untouched
  // entries left after reset stay behind everything touched since
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ages_d[i] = ages_q[i];
    end
    if (touch_en) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if ((IDX_W'(i) != touch_idx) && (ages_q[i] <= ages_q[touch_idx]) &&
            (ages_q[i] != {AGE_W{1'b1}})) begin
          ages_d[i] = ages_q[i] + AGE_W'(1);
        end
      end
      ages_d[touch_idx] = '0;
    end
  end

  // Oldest entry wins; ties go to the lowest index
  always_comb begin
    victim_idx_c = '0;
    best_age     = ages_q[0];
    for (int unsigned i = 1; i < ENTRIES; i++) begin
      if (ages_q[i] > best_age) begin
        best_age     = ages_q[i];
        victim_idx_c = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!rst) begin
        ages_q[i] <= '0;
      end else begin
        ages_q[i] <= ages_d[i];
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             unused_touch;

  assign unused_touch = ^{touch_en, touch_idx};

  always_comb begin
    ptr_d = ptr_q;
    if (alloc_evict) begin
      ptr_d = ptr_q + IDX_W'(1);
    end
  end

  assign victim_idx_c = ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

endmodule

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer with 2-bit direction counters and
// 0-cycle lookup. Replacement policy selected by BTB_LRU_EN (see btb_replace).
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc_i,
  output logic [31:0]          prepc_o,
  output logic                 hit_o,
  output logic [BTB_IDX_W-1:0] hitpos_o,
  input  logic                 upd_en,
  input  logic [31:0]          upd_pc,
  input  logic [31:0]          upd_target,
  input  logic                 upd_taken,
  input  logic                 upd_hit,
  input  logic [BTB_IDX_W-1:0] upd_hitpos
);

  localparam int unsigned IDX_W = BTB_IDX_W;

  btb_entry_t         ent_q [ENTRIES];
  btb_entry_t         ent_d [ENTRIES];
  logic [ENTRIES-1:0] look_match;
  logic [ENTRIES-1:0] upd_match;
  logic               upd_found;
  logic [IDX_W-1:0]   upd_idx;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               do_upd;
  logic [IDX_W-1:0]   tgt_idx;
  logic               touch_en;
  logic [IDX_W-1:0]   touch_idx;
  logic               alloc_evict;
  logic [IDX_W-1:0]   victim_idx;

  // Lookup: a hit needs exactly one matching valid entry
  always_comb begin
    hitpos_o = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      look_match[i] = ent_q[i].valid && (ent_q[i].tag == pc_i[31:2]);
    end
    hit_o = ($countones(look_match) == 1);
    if (hit_o) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (look_match[i]) begin
          hitpos_o = IDX_W'(i);
        end
      end
    end
    if (hit_o && ((ent_q[hitpos_o].ctr == WT) || (ent_q[hitpos_o].ctr == ST))) begin
      prepc_o = ent_q[hitpos_o].target;
    end else begin
      prepc_o = pc_i + 32'd4;
    end
  end

  // Search for an in-flight allocation of upd_pc and for the lowest free slot
  always_comb begin
    upd_found  = 1'b0;
    upd_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      upd_match[i] = ent_q[i].valid && (ent_q[i].tag == upd_pc[31:2]);
      if (upd_match[i] && !upd_found) begin
        upd_found = 1'b1;
        upd_idx   = IDX_W'(i);
      end
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Update / allocate
  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
    end
    do_upd      = 1'b0;
    tgt_idx     = '0;
    touch_en    = 1'b0;
    touch_idx   = '0;
    alloc_evict = 1'b0;
    if (upd_en) begin
      if (upd_hit) begin
        do_upd  = 1'b1;
        tgt_idx = upd_hitpos;
      end else if (upd_found) begin
        do_upd  = 1'b1;
        tgt_idx = upd_idx;
      end else if (upd_taken) begin
        tgt_idx          = free_found ? free_idx : victim_idx;
        alloc_evict      = !free_found;
        ent_d[tgt_idx]   = '{valid: 1'b1, tag: upd_pc[31:2], target: upd_target, ctr: WT};
        touch_en         = 1'b1;
        touch_idx        = tgt_idx;
      end
      if (do_upd) begin
        ent_d[tgt_idx].ctr = ctr_next(ent_q[tgt_idx].ctr, upd_taken);
        if (upd_taken) begin
          ent_d[tgt_idx].target = upd_target;
        end
        touch_en  = 1'b1;
        touch_idx = tgt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!rst) begin
        ent_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: SNT};
      end else begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  btb_replace #(
    .ENTRIES (ENTRIES)
  ) u_replace (
    .clk          (clk),
    .rst          (rst),
    .touch_en     (touch_en),
    .touch_idx    (touch_idx),
    .alloc_evict  (alloc_evict),
    .victim_idx_c (victim_idx)
  );

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 8, number of fully-associative entries (fixed at 8 to match the 3-bit hitpos).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port pc_i, input, 32: fetch PC to look up.
REQ-005 SHALL have port prepc_o, output, 32: predicted next PC.
REQ-006 SHALL have port hit_o, output, 1: pc_i matched a valid entry.
REQ-007 SHALL have port hitpos_o, output, 3: matching entry index (0 when no hit).
REQ-008 SHALL have port upd_en, input, 1: resolved branch/jump update strobe from EX.
REQ-009 SHALL have port upd_pc, input, 32: PC of the resolved instruction.
REQ-010 SHALL have port upd_target, input, 32: resolved taken target.
REQ-011 SHALL have port upd_taken, input, 1: resolved direction.
REQ-012 SHALL have port upd_hit, input, 1: hit flag carried down the pipe with the instruction.
REQ-013 SHALL have port upd_hitpos, input, 3: hitpos carried down the pipe with the instruction.

Function
REQ-014 Lookup SHALL be combinational, 0-cycle: hit_o=1 iff exactly one valid entry has tag==pc_i[31:2].
REQ-015 prepc_o SHALL equal target[hitpos] when hit_o=1 and counter[hitpos][1]=1; otherwise pc_i+4 (32-bit wrap: 0xFFFFFFFC gives 0x00000000).
REQ-016 Each entry SHALL hold valid, tag[29:0], target[31:0] and a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 On upd_en with upd_hit=1, the entry at upd_hitpos SHALL, one cycle later, have its counter incremented (taken, saturating at 11) or decremented (not taken, saturating at 00); the target SHALL be rewritten when taken.
REQ-018 On upd_en with upd_hit=0, an existing valid entry matching upd_pc (allocated while the instruction was in flight) SHALL be updated per REQ-017; no duplicate entry SHALL be created.
REQ-019 On upd_en, upd_hit=0, no match and upd_taken=1, an entry SHALL be allocated: the lowest-index invalid entry, else the victim per REQ-024; the new entry gets valid=1, tag, target and counter=10.
REQ-020 upd_en with upd_hit=0, no match and upd_taken=0 SHALL change no state.
REQ-021 Lookup and update in the same cycle, including the same PC, SHALL see pre-update state; there is no bypass.
REQ-022 upd_en=0 SHALL leave all state unchanged; stall, flush, halt and interrupt need no inputs here because lookup is stateless.

Reset
REQ-023 When rst=0 at posedge, all valid bits, counters and replacement state SHALL clear to 0, overriding a same-cycle upd_en; outputs then read hit_o=0, hitpos_o=0, prepc_o=pc_i+4.

Configuration
REQ-024 With BTB_LRU_EN defined:
- Victim is the true-LRU entry, tracked as 3-bit per-entry ages.
- The entry touched by an update or allocation becomes age 0; younger entries age by 1.
REQ-025 Without BTB_LRU_EN:
- Victim is a 3-bit round-robin pointer, advanced by 1 (wrapping 7->0) on each allocation that evicts a valid entry.

Structure
REQ-026 A shared package SHALL hold the ENTRIES default, the counter encodings (SNT/WNT/WT/ST) and the entry struct typedef.
REQ-027 Replacement selection SHALL be a single sub-module, btb_replace (LRU or round-robin), outputting the victim index.

Verification
REQ-028 After reset, pc_i=0x00400010 SHALL give hit_o=0, hitpos_o=0, prepc_o=0x00400014.
REQ-029 upd_en, upd_pc=0x00400010, upd_target=0x00400100, taken=1, upd_hit=0, then pc_i=0x00400010 SHALL give hit_o=1, hitpos_o=0, prepc_o=0x00400100.
REQ-030 Two not-taken updates to that entry SHALL drive the counter 10->01->00, and lookup SHALL then give prepc_o=0x00400014 with hit_o still 1.
REQ-031 Nine distinct taken allocations (PCs 0x100, 0x104 ... 0x120) SHALL evict entry 0 in both configurations, so that 0x100 misses and 0x120 hits at position 0.
REQ-032 An update with upd_hit=0 for a PC already present SHALL leave the valid-entry count unchanged and update the existing entry's counter.
REQ-033 rst=0 asserted together with upd_en SHALL leave all entries invalid on the next cycle.
